// File: rtl/check_scan_engine.sv
// Checksum scan engine: on a check request it reads DEPTH words, sums them and reports pass/fail.
// Define CHECK_TIMEOUT_EN to abort a scan whose read response takes longer than TIMEOUT cycles.
module check_scan_engine #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 16,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              check_i,
    input  logic [DATA_W-1:0] expected_i,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic              rd_valid_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic [DATA_W-1:0] sum_o,
    output logic              timeout_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CMP,
        S_DONE
    } state_t;

    // Bad sizing would silently truncate the word index, so refuse to elaborate instead.
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W) || TIMEOUT < 0) begin : g_badParam
        $error("check_scan_engine: DEPTH must be 1..2**ADDR_W and TIMEOUT non-negative");
    end

    state_t             r_state;
    logic [IDX_W-1:0]   r_index;
    logic [DATA_W-1:0]  r_sum;
    logic [ADDR_W-1:0]  r_rdAddr;
    logic               r_rdReq;
    logic               r_done;
    logic               r_pass;
    logic               r_fail;
    logic [IDX_W-1:0]   w_nextIndex;

    assign w_nextIndex = r_index + 1'b1;

`ifdef CHECK_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    logic [TO_W-1:0] r_waitCnt;
    logic            r_timeout;

    assign timeout_o = r_timeout;
`else
    assign timeout_o = 1'b0;
`endif

    // Single FSM: the read strobe and done pulse default low so each lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_index  <= '0;
            r_sum    <= '0;
            r_rdAddr <= '0;
            r_rdReq  <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_fail   <= 1'b0;
`ifdef CHECK_TIMEOUT_EN
            r_waitCnt <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_rdReq <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (check_i) begin
                        r_sum    <= '0;
                        r_index  <= '0;
                        r_pass   <= 1'b0;
                        r_fail   <= 1'b0;
`ifdef CHECK_TIMEOUT_EN
                        r_timeout <= 1'b0;
`endif
                        r_rdReq  <= 1'b1;
                        r_rdAddr <= BASE;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
`ifdef CHECK_TIMEOUT_EN
                    r_waitCnt <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A response in the same cycle the counter expires still counts.
                    if (rd_valid_i) begin
                        r_sum <= r_sum + rd_data_i;
                        if (r_index == LAST_IDX) begin
                            r_state <= S_CMP;
                        end else begin
                            r_index  <= w_nextIndex;
                            r_rdReq  <= 1'b1;
                            r_rdAddr <= BASE + ADDR_W'(w_nextIndex);
                            r_state  <= S_REQ;
                        end
                    end
`ifdef CHECK_TIMEOUT_EN
                    else if (r_waitCnt == TO_MAX) begin
                        r_timeout <= 1'b1;
                        r_fail    <= 1'b1;
                        r_pass    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
`endif
                end
                S_CMP: begin
                    r_pass  <= (r_sum == expected_i);
                    r_fail  <= (r_sum != expected_i);
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_req_o  = r_rdReq;
    assign rd_addr_o = r_rdAddr;
    assign busy_o    = (r_state != S_IDLE);
    assign done_o    = r_done;
    assign pass_o    = r_pass;
    assign fail_o    = r_fail;
    assign sum_o     = r_sum;

endmodule

// File: tb/tb_check_scan_engine.sv
// Directed bench for check_scan_engine: a 32-bit engine on a word-indexed memory model
// and an 8-bit engine whose scan window wraps past the top of the address space.
module tb_check_scan_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        check_i = 1'b0;
    logic [31:0] expected_i = '0;
    logic        rd_req_o;
    logic [7:0]  rd_addr_o;
    logic        rd_valid_i;
    logic [31:0] rd_data_i;
    logic        busy_o, done_o, pass_o, fail_o, timeout_o;
    logic [31:0] sum_o;

    logic        check8 = 1'b0;
    logic [7:0]  expected8 = '0;
    logic        rdReq8;
    logic [7:0]  rdAddr8;
    logic        rdValid8;
    logic [7:0]  rdData8;
    logic        busy8, done8, pass8, fail8, timeout8;
    logic [7:0]  sum8;

    int checks = 0;
    int errors = 0;

    // Memory model controls, written only by the main sequence.
    bit respondEn = 1'b1;
    bit delayRandom = 1'b0;
    bit spurious = 1'b0;

    // Memory model state, written only by the responders.
    int         reqCount = 0;
    logic [7:0] addrLog[$];
    logic [7:0] addrLog8[$];

    always #5 clk = ~clk;

    check_scan_engine #(
        .DATA_W(32), .ADDR_W(8), .DEPTH(16), .BASE_ADDR(0), .TIMEOUT(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .check_i(check_i), .expected_i(expected_i),
        .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_valid_i(rd_valid_i),
        .rd_data_i(rd_data_i), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
        .fail_o(fail_o), .sum_o(sum_o), .timeout_o(timeout_o)
    );

    check_scan_engine #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(16), .BASE_ADDR(250), .TIMEOUT(10)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .check_i(check8), .expected_i(expected8),
        .rd_req_o(rdReq8), .rd_addr_o(rdAddr8), .rd_valid_i(rdValid8),
        .rd_data_i(rdData8), .busy_o(busy8), .done_o(done8), .pass_o(pass8),
        .fail_o(fail8), .sum_o(sum8), .timeout_o(timeout8)
    );

    // Memory for the 32-bit engine: word at address a holds a+1; optional delay and junk valids.
    initial begin
        bit         pending;
        int         waitLeft;
        logic [7:0] pendAddr;
        pending = 1'b0;
        waitLeft = 0;
        pendAddr = '0;
        rd_valid_i = 1'b0;
        rd_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            rd_valid_i = 1'b0;
            rd_data_i = '0;
            if (pending) begin
                if (waitLeft == 0) begin
                    if (respondEn) begin
                        rd_valid_i = 1'b1;
                        rd_data_i = {24'd0, pendAddr} + 32'd1;
                        pending = 1'b0;
                    end
                end else begin
                    waitLeft--;
                end
            end
            if (rd_req_o) begin
                reqCount++;
                addrLog.push_back(rd_addr_o);
                pending = 1'b1;
                pendAddr = rd_addr_o;
                waitLeft = delayRandom ? int'($urandom_range(0, 5)) : 0;
                if (spurious) begin
                    rd_valid_i = 1'b1;
                    rd_data_i = 32'hDEAD_BEEF;
                end
            end else if (!busy_o && spurious) begin
                rd_valid_i = 1'b1;
                rd_data_i = 32'h0BAD_0BAD;
            end
        end
    end

    // Memory for the 8-bit engine: every word is 0xFF, answered one cycle after the request.
    initial begin
        bit pending8;
        pending8 = 1'b0;
        rdValid8 = 1'b0;
        rdData8 = '0;
        forever begin
            @(posedge clk);
            #1;
            rdValid8 = 1'b0;
            rdData8 = '0;
            if (pending8) begin
                rdValid8 = 1'b1;
                rdData8 = 8'hFF;
                pending8 = 1'b0;
            end
            if (rdReq8) begin
                addrLog8.push_back(rdAddr8);
                pending8 = 1'b1;
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        check_i = 1'b0;
        check8 = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done_o); end
        checks++; if (pass_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass: got %b expected 0", pass_o); end
        checks++; if (fail_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_fail: got %b expected 0", fail_o); end
        checks++; if (sum_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_sum: got %0d expected 0", sum_o); end
        checks++; if (rd_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdreq: got %b expected 0", rd_req_o); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeout_o); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pass_scan();
        int  n;
        int  startReq;
        bit  addrOk;
        expected_i = 32'd136;
        startReq = reqCount;
        check_i = 1'b1;
        n = 0;
        while (n < 200 && !done_o) begin
            @(negedge clk);
            n++;
            if (n == 5) begin
                checks++;
                if (busy_o !== 1'b1 || pass_o !== 1'b0 || fail_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL pass_midscan: busy/pass/fail got %b%b%b expected 100", busy_o, pass_o, fail_o);
                end
            end
        end
        check_i = 1'b0;
        checks++; if (n !== 34) begin errors++; $display("[TB] FAIL pass_latency: got %0d cycles expected 34", n); end
        checks++; if (pass_o !== 1'b1) begin errors++; $display("[TB] FAIL pass_pass: got %b expected 1", pass_o); end
        checks++; if (fail_o !== 1'b0) begin errors++; $display("[TB] FAIL pass_fail: got %b expected 0", fail_o); end
        checks++; if (sum_o !== 32'd136) begin errors++; $display("[TB] FAIL pass_sum: got %0d expected 136", sum_o); end
        checks++; if (reqCount - startReq !== 16) begin errors++; $display("[TB] FAIL pass_reqs: got %0d expected 16", reqCount - startReq); end
        addrOk = (addrLog.size() >= startReq + 16);
        if (addrOk) begin
            for (int k = 0; k < 16; k++) begin
                if (addrLog[startReq + k] !== 8'(k)) addrOk = 1'b0;
            end
        end
        checks++; if (addrOk !== 1'b1) begin errors++; $display("[TB] FAIL pass_addrs: got %b expected 1 (addresses 0..15 in order)", addrOk); end
        @(negedge clk);
        checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL pass_done_pulse: got %b expected 0", done_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL pass_idle: got %b expected 0", busy_o); end
        checks++; if (pass_o !== 1'b1) begin errors++; $display("[TB] FAIL pass_hold: got %b expected 1", pass_o); end
    endtask

    task automatic test_fail_scan();
        int n;
        int doneCount;
        expected_i = 32'd135;
        check_i = 1'b1;
        n = 0;
        doneCount = 0;
        while (n < 200 && !done_o) begin
            @(negedge clk);
            n++;
        end
        check_i = 1'b0;
        checks++; if (fail_o !== 1'b1) begin errors++; $display("[TB] FAIL fail_fail: got %b expected 1", fail_o); end
        checks++; if (pass_o !== 1'b0) begin errors++; $display("[TB] FAIL fail_pass: got %b expected 0", pass_o); end
        checks++; if (sum_o !== 32'd136) begin errors++; $display("[TB] FAIL fail_sum: got %0d expected 136", sum_o); end
        if (done_o) doneCount++;
        repeat (6) begin
            @(negedge clk);
            if (done_o) doneCount++;
        end
        checks++; if (doneCount !== 1) begin errors++; $display("[TB] FAIL fail_done_count: got %0d expected 1", doneCount); end
    endtask

    task automatic test_spurious_delays();
        int n;
        int startReq;
        expected_i = 32'd136;
        delayRandom = 1'b1;
        spurious = 1'b1;
        repeat (3) @(negedge clk);
        startReq = reqCount;
        check_i = 1'b1;
        n = 0;
        while (n < 400 && !done_o) begin
            @(negedge clk);
            n++;
        end
        check_i = 1'b0;
        checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL spur_done: got %b expected 1 within 400 cycles", done_o); end
        checks++; if (sum_o !== 32'd136) begin errors++; $display("[TB] FAIL spur_sum: got %0d expected 136", sum_o); end
        checks++; if (pass_o !== 1'b1) begin errors++; $display("[TB] FAIL spur_pass: got %b expected 1", pass_o); end
        checks++; if (reqCount - startReq !== 16) begin errors++; $display("[TB] FAIL spur_reqs: got %0d expected 16", reqCount - startReq); end
        repeat (3) @(negedge clk);
        checks++; if (sum_o !== 32'd136) begin errors++; $display("[TB] FAIL spur_idle_sum: got %0d expected 136", sum_o); end
        delayRandom = 1'b0;
        spurious = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midscan();
        int n;
        expected_i = 32'd136;
        check_i = 1'b1;
        n = 0;
        while (n < 100 && !(rd_req_o && rd_addr_o == 8'd7)) begin
            @(negedge clk);
            n++;
        end
        checks++; if (rd_addr_o !== 8'd7) begin errors++; $display("[TB] FAIL rstmid_reach: got addr %0d expected 7", rd_addr_o); end
        rst_n = 1'b0;
        check_i = 1'b0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy_o); end
        checks++; if (sum_o !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_sum: got %0d expected 0", sum_o); end
        checks++; if (rd_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_rdreq: got %b expected 0", rd_req_o); end
        checks++; if (pass_o !== 1'b0 || fail_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_flags: pass/fail got %b%b expected 00", pass_o, fail_o); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (sum_o !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_late_valid: got sum %0d expected 0", sum_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stay_idle: got %b expected 0", busy_o); end
        check_i = 1'b1;
        n = 0;
        while (n < 200 && !done_o) begin
            @(negedge clk);
            n++;
        end
        check_i = 1'b0;
        checks++; if (n !== 34) begin errors++; $display("[TB] FAIL rstmid_rescan_latency: got %0d expected 34", n); end
        checks++; if (pass_o !== 1'b1 || sum_o !== 32'd136) begin errors++; $display("[TB] FAIL rstmid_rescan: got pass %b sum %0d expected pass 1 sum 136", pass_o, sum_o); end
        @(negedge clk);
    endtask

    task automatic test_wrap8();
        int  n;
        int  startLog;
        bit  addrOk;
        expected8 = 8'hF0;
        startLog = addrLog8.size();
        check8 = 1'b1;
        n = 0;
        while (n < 200 && !done8) begin
            @(negedge clk);
            n++;
        end
        check8 = 1'b0;
        checks++; if (n !== 34) begin errors++; $display("[TB] FAIL wrap_latency: got %0d expected 34", n); end
        checks++; if (sum8 !== 8'hF0) begin errors++; $display("[TB] FAIL wrap_sum: got 0x%0h expected 0xf0", sum8); end
        checks++; if (pass8 !== 1'b1 || fail8 !== 1'b0) begin errors++; $display("[TB] FAIL wrap_pass: pass/fail got %b%b expected 10", pass8, fail8); end
        checks++; if (addrLog8.size() - startLog !== 16) begin errors++; $display("[TB] FAIL wrap_reqs: got %0d expected 16", addrLog8.size() - startLog); end
        // Window starts at 250, so it runs 250..255 and then wraps to 0..9.
        addrOk = (addrLog8.size() >= startLog + 16);
        if (addrOk) begin
            for (int k = 0; k < 16; k++) begin
                if (addrLog8[startLog + k] !== 8'(250 + k)) addrOk = 1'b0;
            end
        end
        checks++; if (addrOk !== 1'b1) begin errors++; $display("[TB] FAIL wrap_addrs: got %b expected 1 (addresses 250..255,0..9)", addrOk); end
        checks++; if (timeout8 !== 1'b0) begin errors++; $display("[TB] FAIL wrap_timeout: got %b expected 0", timeout8); end
        @(negedge clk);
    endtask

    task automatic test_no_response();
        int n;
        int doneSeen;
        respondEn = 1'b0;
        expected_i = 32'd136;
        check_i = 1'b1;
        n = 0;
        while (n < 10 && !rd_req_o) begin
            @(negedge clk);
            n++;
        end
        check_i = 1'b0;
        checks++; if (rd_req_o !== 1'b1) begin errors++; $display("[TB] FAIL noresp_req: got %b expected 1", rd_req_o); end
`ifdef CHECK_TIMEOUT_EN
        // WAIT is entered at the edge ending this REQ cycle; done rises 11 edges later,
        // which is the 12th negedge counted from here.
        n = 0;
        while (n < 50 && !done_o) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 12) begin errors++; $display("[TB] FAIL noresp_latency: got %0d expected 12", n); end
        checks++; if (timeout_o !== 1'b1) begin errors++; $display("[TB] FAIL noresp_timeout: got %b expected 1", timeout_o); end
        checks++; if (fail_o !== 1'b1 || pass_o !== 1'b0) begin errors++; $display("[TB] FAIL noresp_flags: pass/fail got %b%b expected 01", pass_o, fail_o); end
        doneSeen = 0;
`else
        doneSeen = 0;
        repeat (300) begin
            @(negedge clk);
            if (done_o) doneSeen++;
        end
        checks++; if (doneSeen !== 0) begin errors++; $display("[TB] FAIL noresp_done: got %0d pulses expected 0", doneSeen); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL noresp_busy: got %b expected 1", busy_o); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL noresp_timeout: got %b expected 0", timeout_o); end
`endif
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        respondEn = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL noresp_recover: got %b expected 0 (doneSeen %0d)", busy_o, doneSeen); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_pass_scan();
        test_fail_scan();
        test_spurious_delays();
        test_reset_midscan();
        test_wrap8();
        test_no_response();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
